// File: rtl/rom_leb128_reader.sv
// rom_leb128_reader: fetches consecutive bytes from a byte ROM and decodes one
// LEB128 integer (unsigned or signed, up to 32 bits). It reports the value,
// the address just past the encoding and an error flag.
//
// ROM handshake (initiator side): rom_addr/rom_read_en are presented and held
// stable for the whole wait; the responder returns rom_data together with a
// one-cycle rom_ready pulse. rom_read_en drops for the cycle in which the next
// address is set up, so every byte is a separate request window. rom_ready is
// ignored unless a request is outstanding.
module rom_leb128_reader #(
  parameter int ADDR_W    = 32,
  parameter int MAX_BYTES = 5,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              signed_mode,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_read_en,
  input  logic [7:0]        rom_data,
  input  logic              rom_ready,
  output logic              busy,
  output logic              done,
  output logic [31:0]       value,
  output logic [ADDR_W-1:0] next_addr,
  output logic              error
);

  localparam int CNT_W = $clog2(MAX_BYTES + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  // Wide enough that a 7-bit group shifted to its slot never overflows
  localparam int SH_W  = 7 * MAX_BYTES + 32;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] cur_addr;
  logic              sign_q;
  logic              err_q;
  logic              last_b6;
  logic [31:0]       acc;
  logic [CNT_W-1:0]  count;
  logic [TMO_W-1:0]  tmo;

  logic [7:0]        shamt;
  logic [SH_W-1:0]   payload_wide;
  logic [31:0]       acc_next;
  logic              final_slot;
  logic              range_bad;
  logic              overlong;
  logic              last_byte;
  logic [31:0]       fin_value;

  // Byte-accept datapath: place the 7-bit group, check the top-byte range
  // and decide whether this byte ends the encoding.
  always_comb begin
    shamt        = 8'd7 * 8'(count);
    payload_wide = SH_W'(rom_data[6:0]) << shamt;
    acc_next     = acc | payload_wide[31:0];
    final_slot   = (32'(count) + 1 >= MAX_BYTES);
    overlong     = rom_data[7] && final_slot;
    last_byte    = !rom_data[7] || final_slot;
    range_bad    = 1'b0;
    if (32'(count) == 4) begin
      if (sign_q) range_bad = (rom_data[6:3] != 4'h0) && (rom_data[6:3] != 4'hF);
      else        range_bad = (rom_data[6:4] != 3'h0);
    end
    // In FIN, count holds the bytes consumed, so shamt is the extension point
    fin_value = acc;
    if (sign_q && !err_q && last_b6 && (shamt < 8'd32))
      fin_value = acc | (32'hFFFF_FFFF << shamt);
  end

  // Decoder FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      base_addr   <= '0;
      cur_addr    <= '0;
      sign_q      <= 1'b0;
      err_q       <= 1'b0;
      last_b6     <= 1'b0;
      acc         <= '0;
      count       <= '0;
      tmo         <= '0;
      rom_addr    <= '0;
      rom_read_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      value       <= '0;
      next_addr   <= '0;
      error       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_addr <= start_addr;
            cur_addr  <= start_addr;
            sign_q    <= signed_mode;
            acc       <= '0;
            count     <= '0;
            err_q     <= 1'b0;
            last_b6   <= 1'b0;
            busy      <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          rom_addr    <= cur_addr;
          rom_read_en <= 1'b1;
          tmo         <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          if (rom_ready) begin
            acc         <= acc_next;
            count       <= count + 1'b1;
            cur_addr    <= cur_addr + 1'b1;
            last_b6     <= rom_data[6];
            rom_read_en <= 1'b0;
            if (overlong || range_bad) err_q <= 1'b1;
            state       <= last_byte ? FIN : REQ;
          end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
            err_q       <= 1'b1;
            rom_read_en <= 1'b0;
            state       <= FIN;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        FIN: begin
          rom_read_en <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
          value       <= fin_value;
          next_addr   <= base_addr + ADDR_W'(count);
          error       <= err_q;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_leb128_reader.sv
// Directed bench for rom_leb128_reader: a byte-ROM responder that only answers
// a new address, hand-computed LEB128 vectors, timing and handshake checks.
module tb_rom_leb128_reader;

  localparam int ADDR_W  = 32;
  localparam int MAXB    = 5;
  localparam int TMO     = 16;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              signed_mode;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_read_en;
  logic [7:0]        rom_data;
  logic              rom_ready;
  logic              busy;
  logic              done;
  logic [31:0]       value;
  logic [ADDR_W-1:0] next_addr;
  logic              error;

  rom_leb128_reader #(.ADDR_W(ADDR_W), .MAX_BYTES(MAXB), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .signed_mode(signed_mode), .rom_addr(rom_addr), .rom_read_en(rom_read_en),
    .rom_data(rom_data), .rom_ready(rom_ready), .busy(busy), .done(done),
    .value(value), .next_addr(next_addr), .error(error)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  logic [7:0]  mem [0:255];
  int          resp_delay = 0;
  logic [31:0] last_addr  = 32'hFFFF_FFFF;
  logic [31:0] pend_addr  = '0;
  int          wait_cnt   = 0;
  int          addr_unstable = 0;
  int          spur_cnt   = 0;
  int          req_windows = 0;
  int          done_cnt   = 0;
  logic        prev_en    = 1'b0;
  logic [31:0] prev_addr  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- ROM responder and monitors ----------------
  // Answers a request only when the address differs from the last serviced
  // one; optional delay per byte; optional spurious ready pulses while idle.
  initial begin
    rom_ready = 1'b0;
    rom_data  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (done) done_cnt++;
      if (rom_read_en && (!prev_en || rom_addr != prev_addr)) req_windows++;
      prev_en   = rom_read_en;
      prev_addr = rom_addr;
      if (rom_ready) begin
        rom_ready = 1'b0;
      end else if (rom_read_en && rom_addr != last_addr) begin
        if (wait_cnt == 0) pend_addr = rom_addr;
        else if (rom_addr != pend_addr) addr_unstable++;
        if (wait_cnt == resp_delay) begin
          rom_ready = 1'b1;
          rom_data  = mem[rom_addr[7:0]];
          last_addr = rom_addr;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        if (!rom_read_en && spur_cnt > 0) begin
          rom_ready = 1'b1;
          rom_data  = 8'h80;
          spur_cnt--;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load(input int base, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
    mem[base]   = b0;
    mem[base+1] = b1;
    mem[base+2] = b2;
    mem[base+3] = b3;
    mem[base+4] = b4;
  endtask

  // Pulse start, then count edges after the accepting edge until done.
  // poke_at > 0 raises start again (different address) while busy.
  task automatic run_decode(input logic [31:0] a, input logic sm, input int poke_at,
                            output int lat);
    @(negedge clk);
    start = 1'b1; start_addr = a; signed_mode = sm;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      start = (k == poke_at);
      if (start) begin start_addr = 32'hA0; signed_mode = ~sm; end
      if (done) begin lat = k; break; end
    end
    start = 1'b0;
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_result(input string tag, input int lat, input int exp_lat,
                               input logic [31:0] exp_next, input logic exp_err);
    logic [31:0] ev;
    ev = exp_q.pop_front();
    check({tag, "_value"}, value, ev);
    check({tag, "_next"}, next_addr, exp_next);
    check({tag, "_err"}, 32'(error), 32'(exp_err));
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int w0;
    int d0;
    rst_n = 1'b0; start = 1'b0; start_addr = '0; signed_mode = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    load(8'h10, 8'hE5, 8'h8E, 8'h26, 8'h00, 8'h00);
    load(8'h20, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00);
    load(8'h30, 8'hC0, 8'hBB, 8'h78, 8'h00, 8'h00);
    load(8'h50, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F);
    load(8'h60, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F);
    load(8'h70, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
    load(8'h80, 8'hE5, 8'h8E, 8'h26, 8'h00, 8'h00);
    load(8'h90, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00);
    load(8'hB0, 8'h85, 8'h01, 8'h00, 8'h00, 8'h00);
    load(8'hC0, 8'h85, 8'h01, 8'h00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rom_addr", rom_addr, 32'h0);
    check("rst_read_en", 32'(rom_read_en), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_value", value, 32'h0);
    check("rst_next", next_addr, 32'h0);
    check("rst_error", 32'(error), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // ULEB E5 8E 26 -> 624485, three request windows
    w0 = req_windows;
    exp_q.push_back(32'h0009_8765);
    run_decode(32'h10, 1'b0, 0, lat);
    expect_result("uleb3", lat, 7, 32'h13, 1'b0);
    check("uleb3_windows", req_windows - w0, 32'd3);
    @(posedge clk); #1;
    check("uleb3_busy_after", 32'(busy), 32'h0);
    check("uleb3_done_pulse", 32'(done), 32'h0);

    // SLEB 7F -> -1
    exp_q.push_back(32'hFFFF_FFFF);
    run_decode(32'h20, 1'b1, 0, lat);
    expect_result("sleb1", lat, 3, 32'h21, 1'b0);

    // SLEB C0 BB 78 -> -123456
    exp_q.push_back(32'hFFFE_1DC0);
    run_decode(32'h30, 1'b1, 0, lat);
    expect_result("sleb3", lat, 7, 32'h33, 1'b0);

    // Five-byte boundary cases
    exp_q.push_back(32'hFFFF_FFFF);
    run_decode(32'h50, 1'b0, 0, lat);
    expect_result("uleb5_ok", lat, 11, 32'h55, 1'b0);

    exp_q.push_back(32'hFFFF_FFFF);
    run_decode(32'h60, 1'b0, 0, lat);
    expect_result("uleb5_range", lat, 11, 32'h65, 1'b1);

    exp_q.push_back(32'h0000_0000);
    run_decode(32'h70, 1'b0, 0, lat);
    expect_result("overlong", lat, 11, 32'h75, 1'b1);

    // Decode 00 at 0x40, then repeat the address: responder stays silent
    exp_q.push_back(32'h0000_0000);
    run_decode(32'h40, 1'b0, 0, lat);
    expect_result("zero", lat, 3, 32'h41, 1'b0);
    exp_q.push_back(32'h0000_0000);
    run_decode(32'h40, 1'b0, 0, lat);
    expect_result("tmo", lat, TMO + 2, 32'h40, 1'b1);
    check("tmo_read_en_low", 32'(rom_read_en), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("tmo_read_en_later", 32'(rom_read_en), 32'h0);

    // Slow responder: three extra cycles per byte, address held stable
    resp_delay    = 3;
    addr_unstable = 0;
    exp_q.push_back(32'h0009_8765);
    run_decode(32'h80, 1'b0, 0, lat);
    expect_result("slow", lat, 16, 32'h83, 1'b0);
    check("slow_addr_stable", addr_unstable, 32'd0);
    resp_delay = 0;

    // Spurious ready pulses while idle must not start anything
    d0 = done_cnt;
    spur_cnt = 3;
    repeat (10) @(posedge clk);
    #1;
    check("spur_busy", 32'(busy), 32'h0);
    check("spur_no_done", done_cnt - d0, 32'd0);
    check("spur_value_held", value, 32'h0009_8765);

    // Start raised again while busy is ignored
    exp_q.push_back(32'hFFFF_FFFF);
    run_decode(32'h90, 1'b1, 1, lat);
    expect_result("start_busy", lat, 3, 32'h91, 1'b0);
    d0 = done_cnt;
    repeat (6) @(posedge clk);
    #1;
    check("start_busy_no_rerun", done_cnt - d0, 32'd0);
    check("start_busy_idle", 32'(busy), 32'h0);

    // Reset while waiting on the second byte
    resp_delay = 3;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; start_addr = 32'hB0; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_wait_addr", rom_addr, 32'hB1);
    check("mid_wait_en", 32'(rom_read_en), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rom_addr", rom_addr, 32'h0);
    check("mid_rst_read_en", 32'(rom_read_en), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_value", value, 32'h0);
    check("mid_rst_next", next_addr, 32'h0);
    check("mid_rst_error", 32'(error), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("mid_rst_no_done", done_cnt - d0, 32'd0);
    resp_delay = 0;

    // Fresh decode after reset
    exp_q.push_back(32'h0000_0085);
    run_decode(32'hC0, 1'b0, 0, lat);
    expect_result("post_rst", lat, 5, 32'hC2, 1'b0);

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case anything wedges
  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "global time limit");
  end

endmodule

// File: doc/rom_leb128_reader.md
Name: rom_leb128_reader

Overview:
- Initiator side of the byte-ROM read handshake (addr / read_en / data / one-cycle ready pulse) used by the wasm loader.
- On a start command it fetches consecutive bytes from a start address and decodes one LEB128 integer (unsigned or signed, up to 32 bits).
- It reports the decoded value and the address of the first byte after the encoding.
- The wasm section/instruction parser instantiates it for every LEB128 field instead of hand-rolling byte loops.

Parameters:
ADDR_W, 32, width of ROM byte address.
MAX_BYTES, 5, maximum encoded length accepted; a 32-bit result needs 5.
TIMEOUT, 16, cycles to wait for rom_ready per byte before flagging an error; must be at least 2.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request decode; sampled only in IDLE
start_addr  input  ADDR_W  address of first encoded byte, sampled with start
signed_mode  input  1  1 = SLEB128, 0 = ULEB128, sampled with start
rom_addr  output  ADDR_W  byte address presented to ROM
rom_read_en  output  1  read request to ROM
rom_data  input  8  byte returned by ROM, valid when rom_ready=1
rom_ready  input  1  one-cycle pulse: rom_data valid
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse, value/next_addr/error valid
value  output  32  decoded integer, held until next accepted start
next_addr  output  ADDR_W  address after last consumed byte, held like value
error  output  1  valid with done: overlong, out of range, or timeout

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rom_addr=0, rom_read_en=0, busy=0, done=0, value=0, next_addr=0, error=0, byte count=0, timeout counter=0.
- Reset asserted mid-decode: immediate return to IDLE. Partial results are discarded and no done pulse is produced.
- States: IDLE, REQ, WAIT, FIN.
- IDLE:
  - On start=1, latch start_addr, signed_mode; clear accumulator, shift, count, error. Go to REQ.
  - start while not IDLE is ignored.
- REQ (1 cycle):
  - rom_addr = current address, rom_read_en=1, timeout counter cleared. Go to WAIT.
- WAIT:
  - rom_read_en held 1 and rom_addr held stable.
  - On rom_ready: OR (rom_data[6:0] << 7*count) into accumulator (bits above 31 dropped), count++, address++.
  - If rom_data[7]=1 and count<MAX_BYTES, go to REQ. Otherwise go to FIN.
  - rom_ready outside WAIT is ignored.
  - If TIMEOUT cycles elapse without rom_ready: error=1, go to FIN.
  - The responder only answers when the address differs from its last serviced address, so a start at an address equal to the previously read one times out. This behaviour is required; the parent must avoid it.
- FIN (1 cycle):
  - rom_read_en=0, done=1, busy=0 next cycle, value/next_addr registered. Return to IDLE.
  - next_addr = start_addr + bytes consumed.
- Error rules:
  - Final byte still has bit7=1 after MAX_BYTES bytes: error (overlong).
  - Unsigned, 5th byte: bits[6:4] must be 0, else error.
  - Signed, 5th byte: bits[6:3] must be all 0 or all 1, else error.
- Sign extension: if signed_mode, the final byte has bit6=1, and 7*count<32, bits [31:7*count] are set to 1.
- On error: value = accumulator as built, with no sign extension.
- Latency:
  - start accepted at edge 0; rom_read_en first high after edge 1.
  - With a responder that answers next cycle, each byte costs 2 cycles (REQ, WAIT).
  - done pulses the cycle after the last byte's ready.
  - An N-byte decode therefore finishes with done high 2N+1 cycles after start.
- Address arithmetic wraps modulo 2^ADDR_W.

Test Plan:
- ULEB E5 8E 26 at 0x10, signed_mode=0 -> value=0x00098765 (624485), next_addr=0x13, error=0, done exactly 7 cycles after start, three rom_read_en request windows.
- SLEB 7F at 0x20 -> value=0xFFFFFFFF, next_addr=0x21. SLEB C0 BB 78 at 0x30 -> value=0xFFFE1DC0 (-123456), next_addr=0x33.
- Five-byte boundary:
  - ULEB FF FF FF FF 0F -> value=0xFFFFFFFF, error=0.
  - ULEB FF FF FF FF 1F -> error=1.
  - 80 80 80 80 80 -> error=1 (overlong), next_addr=start+5.
- Timeout: decode 00 at 0x40, then start again at 0x40 with a responder that does not answer repeats -> no rom_ready, done with error=1 after TIMEOUT+2 cycles, rom_read_en low afterwards.
- Handshake robustness:
  - Responder delays ready 3 cycles per byte -> same value as the prompt case, rom_addr stable throughout each WAIT.
  - Spurious rom_ready pulses in IDLE and a start pulse while busy -> ignored, result unchanged.
- Reset mid-operation: drop rst_n while WAIT on byte 2 -> all outputs return to reset values within the same cycle, no done. A fresh start then decodes correctly.
